// File: rtl/jedro_1_branch_cmp_seq.sv
// Multi-cycle branch-condition resolver: compares rs1/rs2 CHUNK bits per cycle, MSB chunk first.
// Optional macro JEDRO_1_CMP_EARLY_EXIT_EN stops the compare at the first differing chunk.
module jedro_1_branch_cmp_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_taken_o,
    output logic         rsp_eq_o,
    output logic         rsp_lt_o,
    output logic         rsp_ltu_o,
    output logic         rsp_illegal_o
);

    localparam int NC = N / CHUNK;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NC - 1);

    // state   | meaning
    // ST_IDLE | ready for a request
    // ST_CMP  | comparing chunk idx_q, MSB chunk first
    // ST_DONE | response held until rsp_ready_i
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2:0]     op_q, op_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           found_q, found_d;
    logic           hit_lt_q, hit_lt_d;
    logic           hit_ltu_q, hit_ltu_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           taken_q, taken_d;
    logic           eq_q, eq_d;
    logic           lt_q, lt_d;
    logic           ltu_q, ltu_d;
    logic           illegal_q, illegal_d;

    logic [CHUNK-1:0] a_ch [NC];
    logic [CHUNK-1:0] b_ch [NC];

    for (genvar g = 0; g < NC; g++) begin : g_chunk
        assign a_ch[g] = a_q[g*CHUNK +: CHUNK];
        assign b_ch[g] = b_q[g*CHUNK +: CHUNK];
    end

    logic [CHUNK-1:0] a_cur, b_cur;
    logic             diff, c_ltu, c_lt;
    logic             any_found, sel_lt, sel_ltu, finish;
    logic             op_illegal;

    assign a_cur = a_ch[idx_q];
    assign b_cur = b_ch[idx_q];
    assign diff  = (a_cur != b_cur);
    assign c_ltu = (a_cur < b_cur);
    // Only the top chunk carries the sign bit; lower chunks are magnitude-only.
    assign c_lt  = (idx_q == IDX_LAST) ? ($signed(a_cur) < $signed(b_cur)) : c_ltu;

    // Once the most significant difference is recorded, later chunks cannot override it.
    assign any_found = found_q | diff;
    assign sel_lt    = found_q ? hit_lt_q  : c_lt;
    assign sel_ltu   = found_q ? hit_ltu_q : c_ltu;

`ifdef JEDRO_1_CMP_EARLY_EXIT_EN
    assign finish = diff | (idx_q == '0);
`else
    assign finish = (idx_q == '0);
`endif

    assign op_illegal = (op_q[2:1] == 2'b01);

    function automatic logic decide(input logic [2:0] op, input logic eq,
                                    input logic lt, input logic ltu);
        logic t;
        case (op)
            3'b000:  t = eq;
            3'b001:  t = ~eq;
            3'b100:  t = lt;
            3'b101:  t = ~lt;
            3'b110:  t = ltu;
            3'b111:  t = ~ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        found_d     = found_q;
        hit_lt_d    = hit_lt_q;
        hit_ltu_d   = hit_ltu_q;
        rsp_valid_d = rsp_valid_q;
        taken_d     = taken_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    a_d       = a_i;
                    b_d       = b_i;
                    op_d      = op_i;
                    idx_d     = IDX_LAST;
                    found_d   = 1'b0;
                    hit_lt_d  = 1'b0;
                    hit_ltu_d = 1'b0;
                    state_d   = ST_CMP;
                end
            end
            ST_CMP: begin
                if (finish) begin
                    eq_d        = ~any_found;
                    lt_d        = any_found & sel_lt;
                    ltu_d       = any_found & sel_ltu;
                    illegal_d   = op_illegal;
                    taken_d     = ~op_illegal &
                                  decide(op_q, ~any_found, any_found & sel_lt, any_found & sel_ltu);
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d     = idx_q - 1'b1;
                    found_d   = any_found;
                    hit_lt_d  = sel_lt;
                    hit_ltu_d = sel_ltu;
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            hit_lt_q    <= 1'b0;
            hit_ltu_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            hit_lt_q    <= hit_lt_d;
            hit_ltu_q   <= hit_ltu_d;
            rsp_valid_q <= rsp_valid_d;
            taken_q     <= taken_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
            illegal_q   <= illegal_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_taken_o   = taken_q;
    assign rsp_eq_o      = eq_q;
    assign rsp_lt_o      = lt_q;
    assign rsp_ltu_o     = ltu_q;
    assign rsp_illegal_o = illegal_q;

endmodule

// File: tb/tb_jedro_1_branch_cmp_seq.sv
// Bench for jedro_1_branch_cmp_seq: directed table, hand sequences and randomized model check.
module tb_jedro_1_branch_cmp_seq;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int NC    = N / CHUNK;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [N-1:0]  a_i = '0;
    logic [N-1:0]  b_i = '0;
    logic [2:0]    op_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_taken_o, rsp_eq_o, rsp_lt_o, rsp_ltu_o, rsp_illegal_o;

    int tests_run = 0;
    int tests_failed = 0;

    jedro_1_branch_cmp_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .op_i         (op_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_taken_o  (rsp_taken_o),
        .rsp_eq_o     (rsp_eq_o),
        .rsp_lt_o     (rsp_lt_o),
        .rsp_ltu_o    (rsp_ltu_o),
        .rsp_illegal_o(rsp_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  exp;   // {taken, eq, lt, ltu, illegal}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Branch semantics straight from the ISA: whole-word compares, no chunking.
    function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        logic eq, lt, ltu, t, ill;
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        ill = (op == 3'b010) || (op == 3'b011);
        case (op)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return {t, eq, lt, ltu, ill};
    endfunction

    function automatic int klat(input logic [31:0] a, input logic [31:0] b);
        int k;
        k = NC;
        for (int i = NC - 1; i >= 0; i--) begin
            if (((a >> (i * CHUNK)) & 32'hFF) != ((b >> (i * CHUNK)) & 32'hFF)) begin
                k = NC - i;
                break;
            end
        end
`ifndef JEDRO_1_CMP_EARLY_EXIT_EN
        k = NC;
`endif
        return k;
    endfunction

    function automatic logic [4:0] rsp_vec();
        return {rsp_taken_o, rsp_eq_o, rsp_lt_o, rsp_ltu_o, rsp_illegal_o};
    endfunction

    task automatic scramble();
        a_i         = $urandom;
        b_i         = $urandom;
        op_i        = 3'($urandom);
        req_valid_i = 1'($urandom);
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_req(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [4:0] exp, input int hold);
        int cyc;
        req_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        op_i = op;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk({name, " ready_low"}, 32'(req_ready_o), 32'd0);
        scramble();
        cyc = 0;
        while (!rsp_valid_o && cyc < 20) begin
            @(posedge clk_i); #1;
            cyc++;
            scramble();
        end
        chk({name, " latency"}, cyc, klat(a, b));
        for (int h = 0; h < hold; h++) begin
            chk({name, " hold_valid"}, 32'(rsp_valid_o), 32'd1);
            chk({name, " hold_ready"}, 32'(req_ready_o), 32'd0);
            chk({name, " hold_rsp"}, 32'(rsp_vec()), 32'(exp));
            @(posedge clk_i); #1;
            scramble();
        end
        chk({name, " rsp"}, 32'(rsp_vec()), 32'(exp));
        chk({name, " valid"}, 32'(rsp_valid_o), 32'd1);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        chk({name, " back_idle"}, {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 5'b11000};
        vecs[1] = '{32'h80000000, 32'h00000001, 3'b100, 5'b10100};
        vecs[2] = '{32'h80000000, 32'h00000001, 3'b110, 5'b00100};
        vecs[3] = '{32'h80000000, 32'h00000001, 3'b101, 5'b00100};
        vecs[4] = '{32'h12345678, 32'h12345679, 3'b001, 5'b10110};
        vecs[5] = '{32'h00000001, 32'h80000000, 3'b111, 5'b00010};
        vecs[6] = '{32'h00000005, 32'h00000005, 3'b010, 5'b01001};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 3'b011, 5'b00101};
        vecs[8] = '{32'h00000000, 32'h00000100, 3'b000, 5'b00110};
        vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 3'b101, 5'b10000};

        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        chk("reset ready", 32'(req_ready_o), 32'd1);
        chk("reset valid", 32'(rsp_valid_o), 32'd0);
        chk("reset rsp", 32'(rsp_vec()), 32'd0);

        for (int i = 0; i < 10; i++)
            run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1);

        // Illegal op under backpressure, with a competing request waved at the DUT.
        run_req("illegal_bp", 32'd5, 32'd5, 3'b010, 5'b01001, 5);

        // Reset during the second compare cycle drops the request silently.
        req_valid_i = 1'b1;
        a_i = 32'hCAFE0000;
        b_i = 32'hCAFE0000;
        op_i = 3'b000;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i = 1'b0;
        #1;
        chk("midrst ready", 32'(req_ready_o), 32'd1);
        chk("midrst valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(posedge clk_i); #1;
                if (rsp_valid_o) seen++;
            end
            chk("midrst no_rsp", seen, 0);
            chk("midrst idle", 32'(req_ready_o), 32'd1);
        end

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            int          sel;
            a   = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) b = a;
            else if (sel == 1) b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
            else b = $urandom;
            op = 3'($urandom);
            run_req($sformatf("rand%0d", i), a, b, op, model(a, b, op), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
